sram4_pattern_sequencer: RTL and testbench

- Initiator-side controller for the 4-word x 4-bit register-file SRAM used on the LaunchPad datapath.
- Records up to 4 pad nibbles into successive SRAM addresses through a valid/ready input stream.
- Plays them back in order, optionally looped, as a valid/ready output stream at a programmable step rate.
- Sits between pad-scan logic and the SRAM, and owns the SRAM Adress/Din/RW pins.

---
 rtl/sram4_pattern_sequencer_if.sv | 21 ++
 rtl/sram4_pattern_sequencer.sv | 125 ++++++++++++
 tb/tb_sram4_pattern_sequencer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram4_pattern_sequencer_if.sv
// Record and playback valid/ready streams of the SRAM pattern sequencer.
// master = sequencer side, slave = pad-scan / consumer side.
// Pure wiring, no latency; backpressure is carried by rec_ready and play_ready.
interface sram4_pattern_sequencer_if;
    logic       rec_valid;
    logic [3:0] rec_data;
    logic       rec_ready;
    logic       play_valid;
    logic [3:0] play_data;
    logic       play_ready;

    modport master (
        input  rec_valid, rec_data, play_ready,
        output rec_ready, play_valid, play_data
    );

    modport slave (
        output rec_valid, rec_data, play_ready,
        input  rec_ready, play_valid, play_data
    );
endinterface

// File: rtl/sram4_pattern_sequencer.sv
// Records up to 4 nibbles into a 4x4 SRAM and plays them back, optionally looped.
// Latency: record write 1 cycle after accept; playback read-to-read every TICK_DIV cycles.
// Backpressure: rec_ready low outside IDLE/when full; play_data held while play_ready is low.
module sram4_pattern_sequencer #(
    parameter int TICK_DIV = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          clear,
    input  logic                          play_start,
    input  logic                          play_stop,
    input  logic                          play_loop,
    sram4_pattern_sequencer_if.master     io,
    output logic [2:0]                    rec_count,
    output logic                          playing,
    output logic [1:0]                    mem_addr,
    output logic [3:0]                    mem_din,
    output logic                          mem_rw,
    input  logic [3:0]                    mem_dout
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_REC_WR    = 3'd1;
    localparam logic [2:0] S_PLAY_RD   = 3'd2;
    localparam logic [2:0] S_PLAY_OUT  = 3'd3;
    localparam logic [2:0] S_PLAY_WAIT = 3'd4;

    // With TICK_DIV=2 the read-to-read gap is filled by PLAY_RD + PLAY_OUT alone.
    localparam logic [2:0] S_AFTER_OUT = (TICK_DIV == 2) ? S_PLAY_RD : S_PLAY_WAIT;
    localparam int         WCW         = (TICK_DIV > 3) ? $clog2(TICK_DIV - 2) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'((TICK_DIV > 2) ? (TICK_DIV - 3) : 0);

    logic [2:0]     state;
    logic [1:0]     ptr;
    logic [WCW-1:0] wait_cnt;
    logic           start_ok;
    logic           rec_hs;
    logic           last_word;
    logic           in_play;
    logic [1:0]     nxt_ptr;

    assign start_ok     = play_start && (rec_count != 3'd0);
    assign io.rec_ready = (state == S_IDLE) && (rec_count < 3'd4) && !clear && !start_ok;
    assign rec_hs       = io.rec_valid && io.rec_ready;
    assign last_word    = ({1'b0, ptr} == (rec_count - 3'd1));
    assign nxt_ptr      = last_word ? 2'd0 : (ptr + 2'd1);
    assign in_play      = (state == S_PLAY_RD) || (state == S_PLAY_OUT) || (state == S_PLAY_WAIT);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state         <= S_IDLE;
            rec_count     <= 3'd0;
            ptr           <= 2'd0;
            wait_cnt      <= '0;
            mem_addr      <= 2'd0;
            mem_din       <= 4'd0;
            mem_rw        <= 1'b0;
            io.play_valid <= 1'b0;
            io.play_data  <= 4'd0;
            playing       <= 1'b0;
        end else if (in_play && play_stop) begin
            // Stop wins over a same-cycle handshake: no advance, no wrap.
            state         <= S_IDLE;
            io.play_valid <= 1'b0;
            ptr           <= 2'd0;
            playing       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (clear) begin
                        rec_count <= 3'd0;
                    end else if (start_ok) begin
                        ptr      <= 2'd0;
                        mem_addr <= 2'd0;
                        playing  <= 1'b1;
                        state    <= S_PLAY_RD;
                    end else if (rec_hs) begin
                        mem_addr <= rec_count[1:0];
                        mem_din  <= io.rec_data;
                        mem_rw   <= 1'b1;
                        state    <= S_REC_WR;
                    end
                end
                S_REC_WR: begin
                    mem_rw    <= 1'b0;
                    rec_count <= rec_count + 3'd1;
                    state     <= S_IDLE;
                end
                S_PLAY_RD: begin
                    io.play_data  <= mem_dout;
                    io.play_valid <= 1'b1;
                    state         <= S_PLAY_OUT;
                end
                S_PLAY_OUT: begin
                    if (io.play_ready) begin
                        io.play_valid <= 1'b0;
                        wait_cnt      <= '0;
                        if (last_word && !play_loop) begin
                            ptr     <= 2'd0;
                            playing <= 1'b0;
                            state   <= S_IDLE;
                        end else begin
                            ptr      <= nxt_ptr;
                            mem_addr <= nxt_ptr;
                            state    <= S_AFTER_OUT;
                        end
                    end
                end
                S_PLAY_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state <= S_PLAY_RD;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    mem_rw  <= 1'b0;
                    playing <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram4_pattern_sequencer.sv
// Directed bench for sram4_pattern_sequencer with a behavioural 4x4 SRAM model.
module tb_sram4_pattern_sequencer;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       clear = 1'b0;
    logic       play_start = 1'b0;
    logic       play_stop = 1'b0;
    logic       play_loop = 1'b0;
    logic [2:0] rec_count;
    logic       playing;
    logic [1:0] mem_addr;
    logic [3:0] mem_din;
    logic       mem_rw;
    logic [3:0] mem_dout;

    sram4_pattern_sequencer_if sif ();

    sram4_pattern_sequencer #(.TICK_DIV(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .clear      (clear),
        .play_start (play_start),
        .play_stop  (play_stop),
        .play_loop  (play_loop),
        .io         (sif),
        .rec_count  (rec_count),
        .playing    (playing),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_rw     (mem_rw),
        .mem_dout   (mem_dout)
    );

    always #5 CLK = ~CLK;

    // SRAM model: synchronous write, combinational read.
    logic [3:0] sram [4];
    int         cyc    = 0;
    int         wr_cnt = 0;
    assign mem_dout = sram[mem_addr];

    always @(posedge CLK) begin
        cyc++;
        if (mem_rw) begin
            sram[mem_addr] = mem_din;
            wr_cnt++;
        end
    end

    // Playback monitor sampled mid-cycle, where inputs and outputs are stable.
    logic [3:0] hs_dat [64];
    int         rise_cyc [64];
    int         hs_n   = 0;
    int         rise_n = 0;
    logic       pv_q   = 1'b0;

    always @(negedge CLK) begin
        if (sif.play_valid && sif.play_ready && hs_n < 64) begin
            hs_dat[hs_n] = sif.play_data;
            hs_n++;
        end
        if (sif.play_valid && !pv_q && rise_n < 64) begin
            rise_cyc[rise_n] = cyc;
            rise_n++;
        end
        pv_q = sif.play_valid;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Offers one nibble with rec_valid left high; checks the write pulse and count.
    task automatic rec_word(input logic [3:0] d, input int idx, output int acc);
        int g;
        sif.rec_valid = 1'b1;
        sif.rec_data  = d;
        #1;
        g = 0;
        while (!sif.rec_ready && g < 10) begin
            tick();
            g++;
        end
        chk("rec_ready_seen", {31'd0, sif.rec_ready}, 32'd1);
        acc = cyc;
        tick();
        chk("wr_rw", {31'd0, mem_rw}, 32'd1);
        chk("wr_addr", {30'd0, mem_addr}, idx);
        chk("wr_din", {28'd0, mem_din}, {28'd0, d});
        chk("wr_busy_ready", {31'd0, sif.rec_ready}, 32'd0);
        tick();
        chk("wr_rw_drop", {31'd0, mem_rw}, 32'd0);
        chk("wr_count", {29'd0, rec_count}, idx + 1);
    endtask

    task automatic pulse_start();
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pat [4];
        int acc [4];
        int a0, st, rel, rb, hb, na, rn, w0, g;
        pat[0] = 4'h3; pat[1] = 4'hA; pat[2] = 4'h5; pat[3] = 4'hF;
        sif.rec_valid  = 1'b0;
        sif.rec_data   = 4'h0;
        sif.play_ready = 1'b0;
        for (int i = 0; i < 4; i++) sram[i] = 4'h0;

        // Reset state
        tick(); tick();
        chk("rst_count", {29'd0, rec_count}, 32'd0);
        chk("rst_rw", {31'd0, mem_rw}, 32'd0);
        chk("rst_addr", {30'd0, mem_addr}, 32'd0);
        chk("rst_din", {28'd0, mem_din}, 32'd0);
        chk("rst_pv", {31'd0, sif.play_valid}, 32'd0);
        chk("rst_pd", {28'd0, sif.play_data}, 32'd0);
        chk("rst_playing", {31'd0, playing}, 32'd0);
        RST = 1'b1;
        tick();
        chk("idle_ready", {31'd0, sif.rec_ready}, 32'd1);

        // 1: record four nibbles, then a fifth that must be refused
        for (int i = 0; i < 4; i++) rec_word(pat[i], i, acc[i]);
        for (int i = 1; i < 4; i++) chk("rec_spacing", acc[i] - acc[i-1], 32'd2);
        sif.rec_data = 4'hE;
        #1;
        chk("full_ready", {31'd0, sif.rec_ready}, 32'd0);
        chk("full_count", {29'd0, rec_count}, 32'd4);
        tick(); tick(); tick();
        chk("full_no_write", wr_cnt, 32'd4);
        for (int i = 0; i < 4; i++) chk("sram_content", {28'd0, sram[i]}, {28'd0, pat[i]});
        sif.rec_valid = 1'b0;

        // 2: single-pass playback at TICK_DIV=4
        hb = hs_n; rb = rise_n;
        play_loop = 1'b0; sif.play_ready = 1'b1;
        st = cyc;
        pulse_start();
        chk("play_on", {31'd0, playing}, 32'd1);
        for (int i = 0; i < 20; i++) tick();
        chk("p2_hs_n", hs_n - hb, 32'd4);
        for (int i = 0; i < 4; i++) chk("p2_data", {28'd0, hs_dat[hb+i]}, {28'd0, pat[i]});
        chk("p2_first_lat", rise_cyc[rb] - st, 32'd2);
        for (int i = 1; i < 4; i++) chk("p2_step", rise_cyc[rb+i] - rise_cyc[rb+i-1], 32'd4);
        chk("p2_playing_off", {31'd0, playing}, 32'd0);
        chk("p2_count_kept", {29'd0, rec_count}, 32'd4);

        // 3: backpressure on word 1
        hb = hs_n; rb = rise_n;
        pulse_start();
        g = 0;
        while (!(sif.play_valid && sif.play_data == 4'hA) && g < 20) begin
            tick();
            g++;
        end
        chk("p3_word1_seen", {28'd0, sif.play_data}, 32'hA);
        sif.play_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("p3_hold_pv", {31'd0, sif.play_valid}, 32'd1);
            chk("p3_hold_pd", {28'd0, sif.play_data}, 32'hA);
            chk("p3_hold_addr", {30'd0, mem_addr}, 32'd1);
        end
        sif.play_ready = 1'b1;
        rel = cyc;
        for (int i = 0; i < 20; i++) tick();
        chk("p3_rise_n", rise_n - rb, 32'd4);
        chk("p3_resume", rise_cyc[rb+2] - rel, 32'd4);
        chk("p3_hs_n", hs_n - hb, 32'd4);
        for (int i = 0; i < 4; i++) chk("p3_data", {28'd0, hs_dat[hb+i]}, {28'd0, pat[i]});

        // 4: looped playback stopped on the second 0xA handshake
        hb = hs_n;
        play_loop = 1'b1;
        pulse_start();
        na = 0; g = 0;
        while (na < 2 && g < 60) begin
            tick();
            g++;
            if (sif.play_valid && sif.play_data == 4'hA) na++;
        end
        chk("p4_second_a", na, 32'd2);
        play_stop = 1'b1;
        tick();
        play_stop = 1'b0;
        chk("p4_stop_pv", {31'd0, sif.play_valid}, 32'd0);
        chk("p4_stop_playing", {31'd0, playing}, 32'd0);
        rn = rise_n;
        for (int i = 0; i < 12; i++) tick();
        chk("p4_no_reads", rise_n, rn);
        chk("p4_hs_n", hs_n - hb, 32'd6);
        for (int i = 0; i < 6; i++) chk("p4_data", {28'd0, hs_dat[hb+i]}, {28'd0, pat[i%4]});

        // 5: clear, start with empty store, short looped pattern, clear vs record
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("p5_cleared", {29'd0, rec_count}, 32'd0);
        w0 = wr_cnt; rn = rise_n;
        pulse_start();
        chk("p5_empty_idle", {31'd0, playing}, 32'd0);
        for (int i = 0; i < 4; i++) tick();
        chk("p5_empty_idle2", {31'd0, playing}, 32'd0);
        chk("p5_empty_noread", rise_n, rn);
        chk("p5_empty_nowr", wr_cnt, w0);
        rec_word(4'h7, 0, a0);
        rec_word(4'h2, 1, a0);
        sif.rec_valid = 1'b0;
        hb = hs_n;
        pulse_start();
        g = 0;
        while ((hs_n - hb) < 4 && g < 40) begin
            tick();
            g++;
        end
        play_stop = 1'b1;
        tick();
        play_stop = 1'b0;
        chk("p5_loop_hs", ((hs_n - hb) >= 4) ? 32'd1 : 32'd0, 32'd1);
        chk("p5_d0", {28'd0, hs_dat[hb+0]}, 32'h7);
        chk("p5_d1", {28'd0, hs_dat[hb+1]}, 32'h2);
        chk("p5_d2", {28'd0, hs_dat[hb+2]}, 32'h7);
        chk("p5_d3", {28'd0, hs_dat[hb+3]}, 32'h2);
        play_loop = 1'b0;
        tick();
        clear = 1'b1; sif.rec_valid = 1'b1; sif.rec_data = 4'h3;
        #1;
        chk("p5_clr_ready", {31'd0, sif.rec_ready}, 32'd0);
        w0 = wr_cnt;
        tick();
        clear = 1'b0; sif.rec_valid = 1'b0;
        chk("p5_clr_count", {29'd0, rec_count}, 32'd0);
        tick();
        chk("p5_clr_nowr", wr_cnt, w0);
        chk("p5_clr_rw", {31'd0, mem_rw}, 32'd0);

        // 6: asynchronous reset in the middle of a write cycle
        sif.rec_valid = 1'b1; sif.rec_data = 4'h9;
        #1;
        chk("p6_ready", {31'd0, sif.rec_ready}, 32'd1);
        tick();
        sif.rec_valid = 1'b0;
        chk("p6_in_wr", {31'd0, mem_rw}, 32'd1);
        #2;
        RST = 1'b0;
        #1;
        chk("p6_rw_drop", {31'd0, mem_rw}, 32'd0);
        chk("p6_count", {29'd0, rec_count}, 32'd0);
        chk("p6_addr", {30'd0, mem_addr}, 32'd0);
        chk("p6_din", {28'd0, mem_din}, 32'd0);
        chk("p6_pv", {31'd0, sif.play_valid}, 32'd0);
        chk("p6_pd", {28'd0, sif.play_data}, 32'd0);
        chk("p6_playing", {31'd0, playing}, 32'd0);
        w0 = wr_cnt;
        tick(); tick();
        chk("p6_write_lost", wr_cnt, w0);
        chk("p6_sram_kept", {28'd0, sram[0]}, 32'h7);
        #3;
        RST = 1'b1;
        tick();
        chk("p6_rel_ready", {31'd0, sif.rec_ready}, 32'd1);
        chk("p6_rel_count", {29'd0, rec_count}, 32'd0);
        chk("p6_rel_rw", {31'd0, mem_rw}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
